// File: rtl/shift_pla_inverse.sv
// Two-stage streaming decoder that inverts the shift-based tanh PLA activation code.
// Optional error counter enabled by defining SHIFT_PLA_INV_ERRCNT_EN.
module shift_pla_inverse #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 16,
  parameter int OUT_I = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_x,
  output logic             out_sat,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int OUT_F = W_OUT - OUT_I;
  localparam int FR_W  = W_IN - 1;
  localparam int R_W   = $clog2(W_IN);
  localparam int unsigned POS_MAX = (1 << (OUT_I - 1)) - 1;
  localparam int unsigned NEG_MAX = (1 << (OUT_I - 1));
  localparam logic [R_W-1:0] RUN_FULL = R_W'(FR_W);
  localparam logic [W_OUT-1:0] POS_BOUND = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] NEG_BOUND = {1'b1, {(W_OUT-1){1'b0}}};

  // Stage 1 state
  logic            s1_valid;
  logic            s1_sign;
  logic [FR_W-1:0] s1_frac;
  logic [R_W-1:0]  s1_run;

  logic            s2_adv;
  logic [FR_W-1:0] norm;
  logic [R_W-1:0]  run_cnt;
  logic            run_done;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Negative codes count leading zeros: fold them onto a leading-ones count.
  assign norm = in_code[W_IN-2:0] ^ {FR_W{in_code[W_IN-1]}};

  always_comb begin
    run_cnt  = '0;
    run_done = 1'b0;
    for (int unsigned i = 0; i < FR_W; i++) begin
      if (!run_done && norm[FR_W-1-i]) run_cnt = run_cnt + R_W'(1);
      else                             run_done = 1'b1;
    end
  end

  // Stage 2 assembly
  logic [R_W:0]          sh_amt;
  logic [FR_W-1:0]       shifted;
  logic [FR_W+OUT_F-1:0] wide;
  logic [OUT_F-1:0]      frac;
  logic [R_W-1:0]        half;
  int unsigned           half_u;
  logic [OUT_I-1:0]      mag;
  logic [OUT_I-1:0]      int_field;
  logic                  parity_err;
  logic                  full;
  logic                  clamp;
  logic [W_OUT-1:0]      nx_x;
  logic                  nx_sat;
  logic                  nx_err;

  always_comb begin
    sh_amt     = {1'b0, s1_run} + (R_W+1)'(1);
    shifted    = s1_frac << sh_amt;
    wide       = {shifted, {OUT_F{1'b0}}};
    frac       = wide[FR_W+OUT_F-1 -: OUT_F];
    half       = s1_run >> 1;
    half_u     = 32'(half);
    mag        = OUT_I'(half);
    int_field  = s1_sign ? (~mag + OUT_I'(1)) : mag;
    parity_err = s1_sign ? s1_run[0] : !s1_run[0];
    full       = (s1_run == RUN_FULL);
    clamp      = s1_sign ? (half_u > NEG_MAX) : (half_u > POS_MAX);
    nx_x       = {int_field, frac};
    nx_sat     = 1'b0;
    nx_err     = parity_err;
    if (full) begin
      nx_x   = s1_sign ? NEG_BOUND : POS_BOUND;
      nx_sat = 1'b1;
      nx_err = 1'b0;
    end else if (clamp) begin
      nx_x   = s1_sign ? NEG_BOUND : POS_BOUND;
      nx_sat = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_frac   <= '0;
      s1_run    <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_code[W_IN-1];
          s1_frac <= in_code[W_IN-2:0];
          s1_run  <= run_cnt;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_x   <= nx_x;
          out_sat <= nx_sat;
          out_err <= nx_err;
        end
      end
    end
  end

`ifdef SHIFT_PLA_INV_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_cnt_q <= '0;
    end else if (cnt_clr) begin
      err_cnt_q <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_cnt        = '0;
`endif

endmodule
